// File: rtl/frame_minmax8.sv
// Streaming frame statistics: running max/min, first index of max and an all-equal flag
// over FRAME_LEN unsigned samples, presented on a valid/ready result port.
module frame_minmax8 #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [7:0]       out_max_idx,
    output logic             out_all_eq
);

    localparam logic [7:0] LEN = 8'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [7:0]       count, count_nxt;
    logic [WIDTH-1:0] run_max, run_min, max_nxt, min_nxt;
    logic [7:0]       run_idx, idx_nxt;
    logic             accept, frame_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        in_ready   = (state != HOLD);
        out_valid  = (state == HOLD);
        accept     = in_valid && in_ready;
        max_nxt    = run_max;
        min_nxt    = run_min;
        idx_nxt    = run_idx;
        count_nxt  = count + 8'd1;
        state_nxt  = state;
        // The first sample seeds the running values; later ones compare strictly so ties keep the earliest index.
        if (state == IDLE) begin
            max_nxt = in_data;
            min_nxt = in_data;
            idx_nxt = 8'd0;
        end else begin
            if (in_data > run_max) begin
                max_nxt = in_data;
                idx_nxt = count;
            end
            if (in_data < run_min) begin
                min_nxt = in_data;
            end
        end
        frame_done = accept && (count_nxt == LEN);
        case (state)
            IDLE:    if (accept) state_nxt = frame_done ? HOLD : ACCUM;
            ACCUM:   if (frame_done) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (accept) begin
            count <= frame_done ? 8'd0 : count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            run_max <= max_nxt;
            run_min <= min_nxt;
            run_idx <= idx_nxt;
        end
    end

    // Result registers are loaded from the running values that include the final sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= 8'd0;
            out_all_eq  <= 1'b0;
        end else if (frame_done) begin
            out_max     <= max_nxt;
            out_min     <= min_nxt;
            out_max_idx <= idx_nxt;
            out_all_eq  <= (max_nxt == min_nxt);
        end
    end

endmodule

// File: tb/tb_frame_minmax8.sv
// Bench for frame_minmax8: frame-level reference model checked every cycle, plus
// hand-computed expectations for directed frames (FRAME_LEN=4 and FRAME_LEN=1 instances).
module tb_frame_minmax8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid, out_all_eq;
    logic [7:0] out_max, out_min, out_max_idx;

    logic       in_valid_b = 1'b0, out_ready_b = 1'b1;
    logic [7:0] in_data_b = 8'h00;
    logic       in_ready_b, out_valid_b, out_all_eq_b;
    logic [7:0] out_max_b, out_min_b, out_max_idx_b;

    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    frame_minmax8 #(.WIDTH(8), .FRAME_LEN(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_min(out_min), .out_max_idx(out_max_idx),
        .out_all_eq(out_all_eq));

    frame_minmax8 #(.WIDTH(8), .FRAME_LEN(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_max(out_max_b), .out_min(out_min_b), .out_max_idx(out_max_idx_b),
        .out_all_eq(out_all_eq_b));

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Frame-level reference: collect accepted samples, derive the result from the whole frame.
    int   q[$];
    logic m_valid = 0, m_eq = 0;
    int   m_max = 0, m_min = 0, m_idx = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_valid = 0; m_max = 0; m_min = 0; m_idx = 0; m_eq = 0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (in_valid) begin
            q.push_back(int'(in_data));
            if (q.size() == 4) begin
                m_max = q[0]; m_min = q[0]; m_idx = 0; m_eq = 1;
                for (int i = 1; i < q.size(); i++) begin
                    if (q[i] > m_max) begin m_max = q[i]; m_idx = i; end
                    if (q[i] < m_min) m_min = q[i];
                    if (q[i] != q[0]) m_eq = 0;
                end
                m_valid = 1;
                q.delete();
            end
        end
    end

    logic mb_valid = 0;
    int   mb_val = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mb_valid = 0; mb_val = 0;
        end else if (mb_valid) begin
            if (out_ready_b) mb_valid = 0;
        end else if (in_valid_b) begin
            mb_val = int'(in_data_b);
            mb_valid = 1;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("a_out_valid", int'(out_valid), int'(m_valid));
        chk("a_in_ready", int'(in_ready), int'(!m_valid));
        chk("a_out_max", int'(out_max), m_max);
        chk("a_out_min", int'(out_min), m_min);
        chk("a_out_idx", int'(out_max_idx), m_idx);
        chk("a_out_eq", int'(out_all_eq), int'(m_eq));
        chk("b_out_valid", int'(out_valid_b), int'(mb_valid));
        chk("b_out_max", int'(out_max_b), mb_val);
        chk("b_out_min", int'(out_min_b), mb_val);
    end

    task automatic send(input logic [7:0] v);
        logic acc;
        int   n = 0;
        in_valid = 1'b1;
        in_data  = v;
        do begin
            acc = in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input int emax, input int emin,
                            input int eidx, input int eeq, output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_valid"}, int'(out_valid), 1);
        chk({nm, "_max"}, int'(out_max), emax);
        chk({nm, "_min"}, int'(out_min), emin);
        chk({nm, "_idx"}, int'(out_max_idx), eidx);
        chk({nm, "_eq"}, int'(out_all_eq), eeq);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Reset released mid-cycle.
        @(negedge clk); @(negedge clk);
        #3 reset_n = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_max", int'(out_max), 0);
        chk("rst_out_min", int'(out_min), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Partial frame discarded by a reset pulse.
        @(negedge clk);
        send(8'h11); send(8'h22);
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        send(8'h05); send(8'h09); send(8'h03); send(8'h07);
        wait_out("rstframe", 'h09, 'h03, 1, 0, lat);
        @(negedge clk);

        // Basic back-to-back frame with out_ready held high.
        send(8'h02); send(8'h01); send(8'h14); send(8'h0B);
        wait_out("basic", 'h14, 'h01, 2, 0, lat);
        chk("basic_latency", lat, 0);
        @(negedge clk);
        chk("basic_valid_fall", int'(out_valid), 0);
        chk("basic_in_ready", int'(in_ready), 1);

        // Ties and extremes.
        send(8'hFF); send(8'hFE); send(8'hFF); send(8'h00);
        wait_out("ties", 'hFF, 'h00, 0, 0, lat);
        @(negedge clk);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        wait_out("alleq", 'h00, 'h00, 0, 1, lat);
        @(negedge clk);

        // Backpressure with a pending sample offered throughout HOLD.
        out_ready = 1'b0;
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        wait_out("bp", 'h40, 'h10, 3, 0, lat);
        in_valid = 1'b1;
        in_data  = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_valid_held", int'(out_valid), 1);
            chk("bp_max_held", int'(out_max), 'h40);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_fall", int'(out_valid), 0);
        chk("bp_in_ready_back", int'(in_ready), 1);
        chk("bp_max_retained", int'(out_max), 'h40);
        in_valid = 1'b0;
        @(negedge clk);

        // Gaps between samples.
        send(8'h0F); repeat (2) begin @(negedge clk); chk("gap_no_valid", int'(out_valid), 0); end
        send(8'h26); repeat (2) begin @(negedge clk); chk("gap_no_valid", int'(out_valid), 0); end
        send(8'h01); repeat (2) begin @(negedge clk); chk("gap_no_valid", int'(out_valid), 0); end
        send(8'h10);
        wait_out("gaps", 'h26, 'h01, 1, 0, lat);
        chk("gaps_latency", lat, 0);
        @(negedge clk);

        // Single-sample frames.
        chk("b_in_ready", int'(in_ready_b), 1);
        in_valid_b = 1'b1;
        in_data_b  = 8'h7A;
        @(negedge clk);
        in_valid_b = 1'b0;
        chk("len1_valid", int'(out_valid_b), 1);
        chk("len1_max", int'(out_max_b), 'h7A);
        chk("len1_min", int'(out_min_b), 'h7A);
        chk("len1_idx", int'(out_max_idx_b), 0);
        chk("len1_eq", int'(out_all_eq_b), 1);
        @(negedge clk);
        chk("len1_valid_fall", int'(out_valid_b), 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
